// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ready waits.
// Optional memory-wait watchdog enabled by defining MCU_WATCHDOG_EN.
module multicycle_control_unit #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic        offset_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        dm_read,
  output logic        dm_write,
  output logic        halted,
  output logic        wdog_err,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [4:0] OP_AR = 5'b00000;
  localparam logic [4:0] OP_T  = 5'b00001;
  localparam logic [4:0] OP_I  = 5'b00010;
  localparam logic [4:0] OP_J  = 5'b00011;
  localparam logic [4:0] OP_M  = 5'b00100;
  localparam logic [4:0] OP_L1 = 5'b00101;
  localparam logic [4:0] OP_L2 = 5'b00110;
  localparam logic [4:0] OP_Q  = 5'b00111;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] cnt_q, cnt_d;
  logic        run;
  logic        st_fetch, st_exec, st_mem, st_wb;
  logic        is_j, is_m, is_l1, is_l2;
  logic        legal;
  logic        wd_trip;

  assign run      = ~RESET;
  assign st_fetch = (state_q == S_FETCH);
  assign st_exec  = (state_q == S_EXEC);
  assign st_mem   = (state_q == S_MEM);
  assign st_wb    = (state_q == S_WB);

  assign is_j  = (op_q == OP_J);
  assign is_m  = (op_q == OP_M);
  assign is_l1 = (op_q == OP_L1);
  assign is_l2 = (op_q == OP_L2);
  // Only the low eight opcodes form real classes; HLT and the rest halt
  assign legal = (op_q[4:3] == 2'b00);

  // Strobes decode from state and latched opcode; RESET silences them
  assign imem_req   = run & st_fetch;
  assign ir_load    = run & st_fetch & imem_ready;
  assign pc_write   = run & ((st_exec & (is_j | is_m))
                    | (st_mem & is_l2 & dmem_ready)
                    | st_wb);
  assign pc_src     = run & st_exec & (is_j | (is_m & branch_taken));
  assign offset_sel = run & st_exec & is_m;
  assign reg_write  = run & st_wb;
  assign dm_read    = run & st_mem & is_l1;
  assign dm_write   = run & st_mem & is_l2;
  assign halted     = (state_q == S_HALT);
  assign instr_count = cnt_q;

  // Per-class ALU and write-back selects from the latched opcode
  always_comb begin
    alu_op      = 4'b0000;
    alu_src_imm = 1'b0;
    wb_sel      = 2'b00;
    case (op_q)
      OP_AR: alu_op = 4'b0000;
      OP_T: begin
        alu_op = 4'b0001;
        wb_sel = 2'b10;
      end
      OP_I: begin
        alu_op      = 4'b0010;
        alu_src_imm = 1'b1;
      end
      OP_J: alu_op = 4'b0011;
      OP_M: alu_op = 4'b0100;
      OP_L1: begin
        alu_op      = 4'b0101;
        alu_src_imm = 1'b1;
        wb_sel      = 2'b01;
      end
      OP_L2: begin
        alu_op      = 4'b0110;
        alu_src_imm = 1'b1;
      end
      OP_Q: begin
        alu_op = 4'b0111;
        wb_sel = 2'b11;
      end
      default: alu_op = 4'b0000;
    endcase
  end

  // Sequencer next-state: waits in FETCH/MEM, HALT absorbs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_j | is_m)        state_d = S_FETCH;
        else if (is_l1 | is_l2) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM:    if (dmem_ready) state_d = is_l1 ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (wd_trip) state_d = S_HALT;
  end

  assign op_d  = ir_load ? opcode : op_q;
  assign cnt_d = cnt_q + {31'b0, pc_write};

  // State, opcode latch and retire counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      op_q    <= 5'b00000;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MCU_WATCHDOG_EN
  localparam int unsigned WW =
    ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          werr_q;
  logic          wait_st, wait_rdy;

  assign wait_st  = st_fetch | st_mem;
  assign wait_rdy = st_fetch ? imem_ready : dmem_ready;
  assign wd_trip  = wait_st & ~wait_rdy
                  & (wcnt_q == WW'(WDOG_CYCLES - 1));
  assign wcnt_d   = (wait_st & ~wait_rdy) ? wcnt_q + 1'b1 : '0;
  assign wdog_err = werr_q;

  // Wait-cycle counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_q | wd_trip;
    end
  end
`else
  assign wd_trip  = 1'b0;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit.
// Expected per-cycle traces are generated from the instruction-class rules.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [4:0]  opcode = 5'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_load, pc_write, pc_src, offset_sel;
  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_write;
  logic [1:0]  wb_sel;
  logic        dm_read, dm_write, halted, wdog_err;
  logic [31:0] instr_count;
  logic [6:0]  got_strb;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned m_cnt = 0;

  multicycle_control_unit #(.WDOG_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .offset_sel(offset_sel), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .wb_sel(wb_sel), .dm_read(dm_read), .dm_write(dm_write),
    .halted(halted), .wdog_err(wdog_err),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  // {imem_req, ir_load, pc_write, reg_write, dm_read, dm_write, halted}
  assign got_strb = {imem_req, ir_load, pc_write, reg_write,
                     dm_read, dm_write, halted};

  typedef struct {
    logic [4:0] op;
    logic       br, ir, dr;
    logic [6:0] strb;
    logic       ps, os;
    logic       ac;
  } cyc_t;

  cyc_t q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t cy(input logic [4:0] op, input logic br,
                              input logic ir, input logic dr,
                              input logic [6:0] s, input logic ps,
                              input logic os, input logic ac);
    cyc_t c;
    c.op = op; c.br = br; c.ir = ir; c.dr = dr;
    c.strb = s; c.ps = ps; c.os = os; c.ac = ac;
    return c;
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] r5();
    return 5'($urandom);
  endfunction

  // Class table: ALU code plus which selects the class defines
  function automatic void ref_fields(input logic [4:0] op,
    output logic [3:0] a, output logic ei, output logic i_ok,
    output logic [1:0] ew, output logic w_ok);
    a = 4'(op); ei = 1'b0; i_ok = 1'b0; ew = 2'b00; w_ok = 1'b0;
    case (op)
      5'd0: begin i_ok = 1; w_ok = 1; end
      5'd1: begin ew = 2'b10; w_ok = 1; end
      5'd2: begin ei = 1; i_ok = 1; w_ok = 1; end
      5'd5: begin ei = 1; i_ok = 1; ew = 2'b01; w_ok = 1; end
      5'd6: begin ei = 1; i_ok = 1; end
      5'd7: begin ew = 2'b11; w_ok = 1; end
      default: ;
    endcase
  endfunction

  // Expected cycle-by-cycle trace for one instruction
  function automatic void build(input logic [4:0] op, input int iw,
                                input int dw, input logic br);
    q.delete();
    for (int k = 0; k <= iw; k++)
      q.push_back(cy((k == iw) ? op : r5(), r1(), k == iw, r1(),
                     {1'b1, k == iw, 5'b0}, 0, 0, 0));
    q.push_back(cy(r5(), r1(), r1(), r1(), 7'b0, 0, 0, op < 5'd8));
    if (op >= 5'd8) begin
      for (int k = 0; k < 3; k++)
        q.push_back(cy(r5(), r1(), r1(), r1(), 7'b0000001, 0, 0, 0));
      return;
    end
    if (op == 5'd3)
      q.push_back(cy(r5(), r1(), r1(), r1(), 7'b0010000, 1, 0, 1));
    else if (op == 5'd4)
      q.push_back(cy(r5(), br, r1(), r1(), 7'b0010000, br, 1, 1));
    else
      q.push_back(cy(r5(), r1(), r1(), r1(), 7'b0, 0, 0, 1));
    if (op == 5'd5 || op == 5'd6)
      for (int k = 0; k <= dw; k++)
        q.push_back(cy(r5(), r1(), r1(), k == dw,
                       (op == 5'd5) ? 7'b0000100
                                    : {2'b00, k == dw, 4'b0010},
                       0, 0, 1));
    if (op != 5'd3 && op != 5'd4 && op != 5'd6)
      q.push_back(cy(r5(), r1(), r1(), r1(), 7'b0011000, 0, 0, 1));
  endfunction

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    opcode = r5(); branch_taken = 1'b1;
    @(posedge CLK); #4;
    chk("rst_strb", 32'(got_strb), 32'd0);
    chk("rst_pcsel", {30'd0, pc_src, offset_sel}, 32'd0);
    chk("rst_alu", {25'd0, alu_op, alu_src_imm, wb_sel}, 32'd0);
    chk("rst_icnt", instr_count, 32'd0);
    chk("rst_wdog", 32'(wdog_err), 32'd0);
    m_cnt = 0;
  endtask

  task automatic run_instr(input logic [4:0] op, input int iw,
                           input int dw, input logic br,
                           input int abort);
    logic [3:0] ea;
    logic       ei, i_ok, w_ok;
    logic [1:0] ew;
    build(op, iw, dw, br);
    ref_fields(op, ea, ei, i_ok, ew, w_ok);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge CLK); #1;
      RESET = 1'b0;
      opcode = q[i].op; branch_taken = q[i].br;
      imem_ready = q[i].ir; dmem_ready = q[i].dr;
      if (i == abort) begin
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; imem_ready = 1'b0;
        dmem_ready = r1(); opcode = r5();
        #3;
        m_cnt = 0;
        chk("abort_strb", 32'(got_strb), 32'h40);
        chk("abort_icnt", instr_count, 32'd0);
        return;
      end
      #3;
      chk("strb", 32'(got_strb), 32'(q[i].strb));
      if (q[i].strb[4])
        chk("pcsel", {30'd0, pc_src, offset_sel},
            {30'd0, q[i].ps, q[i].os});
      if (q[i].ac) begin
        chk("alu_op", 32'(alu_op), 32'(ea));
        if (i_ok) chk("alu_imm", 32'(alu_src_imm), 32'(ei));
        if (w_ok) chk("wb_sel", 32'(wb_sel), 32'(ew));
      end
      chk("icnt", instr_count, m_cnt);
      chk("wdog", 32'(wdog_err), 32'd0);
      if (q[i].strb[4]) m_cnt++;
    end
    if (op >= 5'd8) do_reset();
  endtask

  initial begin
    logic [4:0] op;
    int         r;
    do_reset();
    run_instr(5'd0, 0, 0, 1'b0, -1);
    run_instr(5'd4, 0, 0, 1'b1, -1);
    run_instr(5'd4, 0, 0, 1'b0, -1);
    run_instr(5'd5, 0, 3, 1'b0, -1);
    run_instr(5'd6, 1, 2, 1'b0, -1);
    run_instr(5'd3, 2, 0, 1'b0, -1);
    run_instr(5'b01010, 0, 0, 1'b0, -1);
    run_instr(5'd0, 0, 0, 1'b0, -1);
    run_instr(5'd6, 0, 3, 1'b0, 4);
    run_instr(5'd31, 1, 0, 1'b0, -1);

`ifdef MCU_WATCHDOG_EN
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      RESET = 1'b0; imem_ready = 1'b0; dmem_ready = r1();
      #3;
      chk("wd_wait", 32'(got_strb), 32'h40);
      chk("wd_wait_err", 32'(wdog_err), 32'd0);
    end
    @(posedge CLK); #4;
    chk("wd_halt", 32'(got_strb), 32'h01);
    chk("wd_err", 32'(wdog_err), 32'd1);
    do_reset();
`else
    for (int k = 0; k < 1000; k++) begin
      @(posedge CLK); #1;
      RESET = 1'b0; imem_ready = 1'b0; dmem_ready = r1();
    end
    #3;
    chk("nowd_strb", 32'(got_strb), 32'h40);
    chk("nowd_err", 32'(wdog_err), 32'd0);
`endif

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)      op = 5'(r % 8);
      else if (r < 18) op = 5'd31;
      else             op = 5'($urandom_range(8, 30));
      run_instr(op, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), r1(),
                ($urandom_range(0, 9) == 0)
                  ? int'($urandom_range(0, 6)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
